// File: rtl/fft_sram_seq.sv
// Write/read sequencer in front of the FFT transpose SRAM: row-wise one-hot writes, column-wise one-hot reads.
// Optional macro FFT_SEQ_COLREAD_EN selects transpose (column) read selects; undefined reads rows back in natural order.
package sram_pkg;
    typedef logic signed [15:0] sfp_t;
    typedef logic [6:0]         addr_t_long;
endpackage

module fft_sram_seq #(
    parameter int AddrLWidth = 7,
    parameter int Beats      = 32,
    parameter int RdLatency  = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  sram_pkg::sfp_t [3:0]        in_dr_i,
    input  sram_pkg::sfp_t [3:0]        in_di_i,
    output logic [4:0]                  wen_o,
    output logic [AddrLWidth-1:0]       addr_wr_o,
    output sram_pkg::sfp_t [3:0]        dr_sram_o,
    output sram_pkg::sfp_t [3:0]        di_sram_o,
    output logic [7:0]                  ren_o,
    output logic [AddrLWidth-1:0]       addr_rd_o,
    input  sram_pkg::sfp_t [3:0]        dr_sram_i,
    input  sram_pkg::sfp_t [3:0]        di_sram_i,
    output logic                        out_valid_o,
    output sram_pkg::sfp_t [3:0]        out_dr_o,
    output sram_pkg::sfp_t [3:0]        out_di_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int BW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int DW = $clog2(RdLatency + 1);

`ifdef FFT_SEQ_COLREAD_EN
    localparam logic [7:0] REN_BASE = 8'h10;
`else
    localparam logic [7:0] REN_BASE = 8'h01;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_GAP, ST_READ, ST_DRAIN, ST_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [BW-1:0]          r_beat;
    logic [1:0]             r_row;
    logic [1:0]             r_col;
    logic [DW-1:0]          r_drn;
    logic [4:0]             r_wen;
    logic [AddrLWidth-1:0]  r_addr_wr;
    sram_pkg::sfp_t [3:0]   r_dr;
    sram_pkg::sfp_t [3:0]   r_di;
    logic [7:0]             r_ren;
    logic [AddrLWidth-1:0]  r_addr_rd;
    logic                   r_issued;
    logic [RdLatency-1:0]   r_vld;
    logic                   r_done;

    logic w_accept, w_beat_last, w_drn_last;

    assign w_accept    = (r_state == ST_WRITE) && in_valid_i;
    assign w_beat_last = (r_beat == BW'(Beats - 1));
    assign w_drn_last  = (r_drn == DW'(RdLatency - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_nxt = ST_WRITE;
            ST_WRITE: if (w_accept && w_beat_last && (r_row == 2'd3)) w_state_nxt = ST_GAP;
            ST_GAP:   w_state_nxt = ST_READ;
            ST_READ:  if (w_beat_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drn_last) w_state_nxt = (r_col == 2'd3) ? ST_DONE : ST_READ;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered SRAM control: everything visible one cycle after the state that produced it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_drn     <= '0;
            r_wen     <= '0;
            r_addr_wr <= '0;
            r_dr      <= '0;
            r_di      <= '0;
            r_ren     <= '0;
            r_addr_rd <= '0;
            r_issued  <= 1'b0;
            r_vld     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wen    <= '0;
            r_issued <= 1'b0;
            r_done   <= (r_state == ST_DONE);
            r_vld[0] <= r_issued;
            for (int i = 1; i < RdLatency; i++) r_vld[i] <= r_vld[i-1];
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                    r_drn  <= '0;
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        r_wen     <= 5'b00001 << r_row;
                        r_addr_wr <= AddrLWidth'(r_beat);
                        r_dr      <= in_dr_i;
                        r_di      <= in_di_i;
                        if (w_beat_last) begin
                            r_beat <= '0;
                            r_row  <= r_row + 2'd1;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                ST_READ: begin
                    r_ren     <= REN_BASE << r_col;
                    r_addr_rd <= AddrLWidth'(r_beat);
                    r_issued  <= 1'b1;
                    if (w_beat_last) begin
                        r_beat <= '0;
                        r_drn  <= '0;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                ST_DRAIN: begin
                    // ren/addr stay put so data still in flight is attributed to this column.
                    if (w_drn_last) begin
                        r_drn <= '0;
                        r_col <= r_col + 2'd1;
                    end else begin
                        r_drn <= r_drn + DW'(1);
                    end
                end
                ST_DONE: begin
                    r_ren     <= '0;
                    r_addr_rd <= '0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_state == ST_WRITE);
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign wen_o       = r_wen;
    assign addr_wr_o   = r_addr_wr;
    assign dr_sram_o   = r_dr;
    assign di_sram_o   = r_di;
    assign ren_o       = r_ren;
    assign addr_rd_o   = r_addr_rd;
    assign out_valid_o = r_vld[RdLatency-1];
    assign out_dr_o    = dr_sram_i;
    assign out_di_o    = di_sram_i;

endmodule
